// File: rtl/regfile_pkg.sv
// Shared constants and state type for the multiport register file.
package regfile_pkg;
  localparam int XLEN_DEFAULT  = 64;
  localparam int NREGS_DEFAULT = 32;

  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;
endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: after every reset, walks all register addresses writing zero,
// then raises ready.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          clrEn,
  output logic [AW-1:0] clrAddr,
  output logic          ready
);

  rf_state_t     state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RF_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clrEn     = 1'b0;
    case (state)
      RF_CLEAR: begin
        clrEn   = !reset;
        cnt_nxt = cnt + 1'b1;
        if (cnt == AW'(NREGS - 1)) begin
          state_nxt = RF_RUN;
          cnt_nxt   = '0;
        end
      end
      RF_RUN: ;
    endcase
  end

  assign clrAddr = cnt;
  assign ready   = (state == RF_RUN);

endmodule

// File: rtl/regfile_multiport.sv
// Multiport integer register file with hardwired-zero x0 and a hardware clear on reset.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rs,
  input  logic [AW-1:0]         rd,
  input  logic                  regWrite,
  input  logic [XLEN-1:0]       writeData,
  output logic [NREAD*XLEN-1:0] readData,
  output logic                  ready,
  output logic                  writeDropped
);

  logic [XLEN-1:0] regs [NREGS];
  logic            clrEn;
  logic [AW-1:0]   clrAddr;
  logic            wrEn;

  regfile_clear_seq #(.NREGS(NREGS), .AW(AW)) u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .clrEn   (clrEn),
    .clrAddr (clrAddr),
    .ready   (ready)
  );

  assign wrEn = !reset && ready && regWrite && (rd != '0);

  // The array has no reset; its contents are defined by the clear walk alone.
  always_ff @(posedge clk) begin
    if (clrEn)
      regs[clrAddr] <= '0;
    else if (wrEn)
      regs[rd] <= writeData;
  end

  always_ff @(posedge clk) begin
    if (reset)
      writeDropped <= 1'b0;
    else if (regWrite && !ready)
      writeDropped <= 1'b1;
  end

  // Zero-register and not-ready forcing win over the bypass.
  always_comb begin
    readData = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (!reset && ready && (rs[i*AW +: AW] != '0)) begin
        readData[i*XLEN +: XLEN] = regs[rs[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (wrEn && (rs[i*AW +: AW] == rd))
          readData[i*XLEN +: XLEN] = writeData;
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: driver pushes model predictions, monitor compares.
module tb_regfile_multiport;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREAD*AW-1:0]   rs = '0;
  logic [AW-1:0]         rd = '0;
  logic                  regWrite = 1'b0;
  logic [XLEN-1:0]       writeData = '0;
  logic [NREAD*XLEN-1:0] readData;
  logic                  ready;
  logic                  writeDropped;

  regfile_multiport #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk          (clk),
    .reset        (reset),
    .rs           (rs),
    .rd           (rd),
    .regWrite     (regWrite),
    .writeData    (writeData),
    .readData     (readData),
    .ready        (ready),
    .writeDropped (writeDropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREAD*XLEN-1:0] rdata;
    logic                  rdy;
    logic                  wd;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: architectural register contents plus edges since reset release.
  logic [XLEN-1:0] m_regs [NREGS];
  int              m_clr = 0;
  logic            m_wd  = 1'b0;

  function automatic exp_t model_read();
    exp_t e;
    e.rdy   = (m_clr == NREGS);
    e.wd    = m_wd;
    e.rdata = '0;
    for (int i = 0; i < NREAD; i++) begin
      int a;
      a = int'(rs[i*AW +: AW]);
      if (!reset && e.rdy && a != 0) begin
        e.rdata[i*XLEN +: XLEN] = m_regs[a];
`ifdef REGFILE_BYPASS_EN
        if (regWrite && rd != 0 && a == int'(rd))
          e.rdata[i*XLEN +: XLEN] = writeData;
`endif
      end
    end
    return e;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_clr = 0;
      m_wd  = 1'b0;
    end else if (m_clr < NREGS) begin
      if (regWrite) m_wd = 1'b1;
      m_clr++;
      if (m_clr == NREGS)
        for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
    end else if (regWrite && rd != 0) begin
      m_regs[int'(rd)] = writeData;
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [XLEN-1:0] d, input logic [AW-1:0] r0,
                      input logic [AW-1:0] r1);
    @(posedge clk);
    model_edge();
    #1;
    reset     = r;
    regWrite  = w;
    rd        = a;
    writeData = d;
    rs        = {r1, r0};
    q.push_back(model_read());
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("readData", 128'(readData), 128'(e.rdata));
        chk("ready", 128'(ready), 128'(e.rdy));
        chk("writeDropped", 128'(writeDropped), 128'(e.wd));
      end
    end
  end

  function automatic logic [AW-1:0] ra();
    return AW'($urandom_range(0, NREGS - 1));
  endfunction

  task automatic rand_steps(input int n, input int rst_odds);
    logic [AW-1:0] a, r0, r1;
    logic          w, r;
    for (int c = 0; c < n; c++) begin
      a  = ra();
      w  = 1'($urandom_range(0, 1));
      r0 = ($urandom_range(0, 3) == 0) ? a : ra();
      r1 = ($urandom_range(0, 3) == 0) ? a : ra();
      r  = (rst_odds > 0) && ($urandom_range(1, rst_odds) == 1);
      step(r, w, a, {$urandom, $urandom}, r0, r1);
    end
  endtask

  initial begin
    for (int k = 0; k < NREGS; k++) m_regs[k] = '0;

    // Reset held 3 cycles, then a clean clear walk with reads in flight.
    repeat (3) step(1'b1, 1'b0, '0, '0, '0, '0);
    for (int c = 0; c < NREGS; c++) step(1'b0, 1'b0, '0, '0, ra(), ra());
    for (int k = 0; k < NREGS / 2; k++)
      step(1'b0, 1'b0, '0, '0, AW'(2 * k), AW'(2 * k + 1));

    // Write/read, zero register, same-cycle read of a written register.
    step(1'b0, 1'b1, AW'(5), 64'hDEAD_BEEF, AW'(5), AW'(5));
    step(1'b0, 1'b0, '0, '0, AW'(5), AW'(5));
    step(1'b0, 1'b1, AW'(0), 64'h1234, AW'(0), AW'(0));
    step(1'b0, 1'b0, '0, '0, AW'(0), AW'(5));
    step(1'b0, 1'b1, AW'(9), 64'hAA, AW'(9), AW'(0));
    step(1'b0, 1'b0, '0, '0, AW'(9), AW'(9));

    rand_steps(300, 0);

    // Mid-run reset, with a write dropped four cycles into the new clear.
    step(1'b0, 1'b1, AW'(3), 64'h77, AW'(0), AW'(0));
    step(1'b0, 1'b0, '0, '0, AW'(3), AW'(3));
    step(1'b1, 1'b0, '0, '0, AW'(3), AW'(7));
    for (int c = 0; c < NREGS; c++)
      step(1'b0, (c == 4), AW'(7), 64'h55, AW'(3), AW'(7));
    step(1'b0, 1'b0, '0, '0, AW'(3), AW'(7));
    step(1'b1, 1'b0, '0, '0, AW'(3), AW'(7));
    for (int c = 0; c < NREGS + 2; c++) step(1'b0, 1'b0, '0, '0, ra(), ra());

    rand_steps(400, 60);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
